// File: rtl/led_scanner_pkg.sv
// ============================================================================
//  Module : led_pkg
//  Shared pattern-mode encodings for the LED scanner and future display blocks.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BOUNCE = 2'd0;
    localparam mode_t MODE_ROT_L  = 2'd1;
    localparam mode_t MODE_ROT_R  = 2'd2;
    localparam mode_t MODE_FILL   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/led_scanner_stb_gen.sv
// ============================================================================
//  Module : stb_gen
//  Pausable prescaler: emits a combinational step strobe once every DIV cycles.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stb_gen #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pause,
    output logic o_stb
);

    localparam int            CW       = $clog2(DIV) + 1;
    localparam logic [CW-1:0] C_RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    logic [CW-1:0] r_cnt;

    // The strobe is taken straight from the count so consumers update on the reload edge.
    assign o_stb = ~i_pause & (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= C_RELOAD;
        end else if (!i_pause) begin
            r_cnt <= (r_cnt == '0) ? C_RELOAD : (r_cnt - C_ONE);
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_scanner.sv
// ============================================================================
//  Module : led_scanner
//  N-bit LED pattern generator (bounce / rotate-left / rotate-right / fill).
//  Optional PWM dimming is enabled with `define LED_SCANNER_PWM_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_scanner
    import led_pkg::*;
#(
    parameter int NLEDS = 8,
    parameter int DIV   = 10
`ifdef LED_SCANNER_PWM_EN
   ,parameter int PWM_W = 4
`endif
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_mode,
    input  logic             i_pause,
`ifdef LED_SCANNER_PWM_EN
    input  logic [PWM_W-1:0] i_duty,
`endif
    output logic [NLEDS-1:0] o_led,
    output logic             o_step,
    output logic             o_dir
);

    localparam int            PW       = $clog2(NLEDS);
    localparam logic [PW-1:0] C_LAST   = PW'(NLEDS - 1);
    localparam logic [PW-1:0] C_PENULT = PW'(NLEDS - 2);
    localparam logic [PW-1:0] C_ONE    = PW'(1);

    logic             w_stb;
    logic [PW-1:0]    r_pos,     w_pos;
    logic             r_dir,     w_dir;
    mode_t            r_mode_q,  w_mode_q;
    logic [NLEDS-1:0] r_pattern, w_pattern;
    logic             r_step;

    stb_gen #(
        .DIV     (DIV)
    ) u_stb_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pause (i_pause),
        .o_stb   (w_stb)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos     <= '0;
            r_dir     <= 1'b0;
            r_mode_q  <= MODE_BOUNCE;
            r_pattern <= NLEDS'(1);
            r_step    <= 1'b0;
        end else begin
            r_pos     <= w_pos;
            r_dir     <= w_dir;
            r_mode_q  <= w_mode_q;
            r_pattern <= w_pattern;
            r_step    <= w_stb;
        end
    end

    always_comb begin
        w_pos     = r_pos;
        w_dir     = r_dir;
        w_mode_q  = r_mode_q;
        w_pattern = r_pattern;
        if (w_stb) begin
            if (i_mode != r_mode_q) begin
                // A mode change restarts the new pattern from LED 0.
                w_mode_q  = i_mode;
                w_pos     = '0;
                w_dir     = 1'b0;
                w_pattern = NLEDS'(1);
            end else begin
                case (r_mode_q)
                    MODE_BOUNCE: begin
                        if (!r_dir) begin
                            if (r_pos == C_LAST) begin
                                w_dir = 1'b1;
                                w_pos = C_PENULT;
                            end else begin
                                w_pos = r_pos + C_ONE;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                w_dir = 1'b0;
                                w_pos = C_ONE;
                            end else begin
                                w_pos = r_pos - C_ONE;
                            end
                        end
                    end
                    MODE_ROT_R: w_pos = (r_pos == '0) ? C_LAST : (r_pos - C_ONE);
                    default:    w_pos = (r_pos == C_LAST) ? '0 : (r_pos + C_ONE);
                endcase
                for (int i = 0; i < NLEDS; i++) begin
                    w_pattern[i] = (r_mode_q == MODE_FILL) ? (PW'(i) <= w_pos)
                                                           : (PW'(i) == w_pos);
                end
            end
        end
    end

`ifdef LED_SCANNER_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;
    logic             r_pwm_on;

    // Free-running so the dimming duty is unaffected by pause.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pwm_cnt <= '0;
            r_pwm_on  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            r_pwm_on  <= (r_pwm_cnt < i_duty);
        end
    end

    always_comb begin
        o_led  = r_pattern & {NLEDS{r_pwm_on}};
        o_step = r_step;
        o_dir  = r_dir;
    end
`else
    always_comb begin
        o_led  = r_pattern;
        o_step = r_step;
        o_dir  = r_dir;
    end
`endif

endmodule

`default_nettype wire
